apb_reg_bridge: RTL and testbench
=================================

Name: apb_reg_bridge

Overview:
- Parametrised APB3 slave to register-file bridge; successor of the fixed zero-wait APB decoder in the APB-to-SPI path.
- Decodes a configurable address window, forwards accesses over a req/ack handshake, and inserts wait states until the register side answers.
- Drives PSLVERR for decode errors, register errors and, optionally, timeouts.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, data width; multiple of 8.
- BASE_ADDR, 32'h4000_2000, window base; aligned to 2**WIN_BITS.
- WIN_BITS, 12, window size is 2**WIN_BITS bytes; also o_addr width.
- REG_SPAN, 12'h018, offsets >= REG_SPAN inside the window are decode errors.
- TIMEOUT, 16, maximum cycles in REQ before a forced error; range 2..255.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  1 = write.
- i_paddr  in  ADDR_W  APB address.
- i_pwdata  in  DATA_W  write data.
- i_pstrb  in  DATA_W/8  byte strobes; reads ignore it.
- o_prdata  out  DATA_W  read data; zero except in the completing cycle.
- o_pready  out  1  transfer complete; registered.
- o_pslverr  out  1  error; valid only while o_pready = 1.
- o_req  out  1  register access request; held until i_ack.
- o_we  out  1  1 = write access.
- o_addr  out  WIN_BITS  byte offset inside the window.
- o_wdata  out  DATA_W  latched write data.
- o_wstrb  out  DATA_W/8  latched strobes.
- i_ack  in  1  register side done; may come in the same cycle o_req rises.
- i_rdata  in  DATA_W  read data; sampled with i_ack.
- i_error  in  1  register error; sampled with i_ack.

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - state goes to IDLE; every output = 0; timeout counter = 0.
  - Reset overrides everything; an access in flight is dropped with no response.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Setup is detected on i_psel & !i_penable.
  - Latch addr, write flag, wdata and strb; decode the address.
- Decode:
  - In-window means i_paddr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS].
  - In-window, offset < REG_SPAN and i_paddr[1:0] == 0 -> REQ; o_req = 1 on the next edge.
  - In-window with offset >= REG_SPAN or misaligned -> RESP with error = 1; no register access.
  - Out of window -> RESP with error = 0 and prdata = 0; no register access.
- REQ:
  - o_req stays high; outputs hold the latched values.
  - On i_ack: capture i_rdata (reads only) and i_error; drop o_req; go to RESP.
- RESP:
  - o_pready = 1 for exactly one cycle.
  - o_pslverr = captured error.
  - o_prdata = captured data for an error-free read, else 0.
  - Next state is IDLE.
- Latency: minimum one APB wait state, i.e. PREADY in the second access cycle when i_ack arrives in the first REQ cycle.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted with no bubble.
- i_psel falls while in REQ (protocol abort):
  - o_req drops on the next edge; go to IDLE; no PREADY.
  - A late i_ack is ignored.
- Stray i_ack while in IDLE or RESP: ignored.
- Writes never drive o_prdata; reads drive o_wstrb = 0.

Optional Feature:
- Macro APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without i_ack.
  - At TIMEOUT, o_req drops and the FSM goes to RESP with error = 1 and prdata = 0.
  - If i_ack arrives in the same cycle the counter reaches TIMEOUT, i_ack wins.
- Undefined: no counter; REQ waits for i_ack indefinitely; TIMEOUT is unused.

Decomposition:
- Package apb_bridge_pkg holds:
  - the state enum {IDLE, REQ, RESP};
  - the response enum {RESP_OK, RESP_ERR};
  - the default BASE_ADDR and REG_SPAN constants.
- One sub-module, apb_addr_decode: combinational window, span and alignment check, outputs {hit, err}, reused by future APB peripherals.

Test Plan:
- Write 0xA5A5_1234 to 0x4000_2004 with strb 4'hF, i_ack in the first REQ cycle -> o_addr = 0x004, o_we = 1, o_wstrb = 4'hF; PREADY at access cycle 2; PSLVERR = 0.
- Read 0x4000_2010 with i_ack after 3 cycles and i_rdata 0xDEAD_BEEF -> PREADY after 4 wait cycles; o_prdata = 0xDEAD_BEEF only in the PREADY cycle.
- Read 0x4000_2020 (offset >= span) and 0x4000_2006 (misaligned) -> o_req stays 0; PREADY with PSLVERR = 1; o_prdata = 0.
- Read 0x4000_3000 (outside window) -> no o_req; PREADY, PSLVERR = 0, o_prdata = 0.
- Write with i_error = 1 alongside i_ack -> PSLVERR = 1. With APB_BRIDGE_TIMEOUT_EN and no i_ack -> PSLVERR = 1 after 16 REQ cycles.
- Assert i_rst in the second REQ cycle -> all outputs 0 on the next edge; the following read of 0x4000_2000 completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and default constants for the APB register bridge family.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } resp_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_2000;
    localparam logic [11:0] DEF_REG_SPAN  = 12'h018;
    localparam int unsigned TMO_CNT_W     = 8;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB window decode: hit = legal register access,
// err = inside the window but beyond the register span or misaligned.
module apb_addr_decode #(
    parameter int unsigned           ADDR_W    = 32,
    parameter int unsigned           WIN_BITS  = 12,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(32'h4000_2000),
    parameter logic [WIN_BITS-1:0]   REG_SPAN  = WIN_BITS'(12'h018)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic              err
);

    logic in_win;
    logic in_span;
    logic aligned;

    // window, span and word-alignment tests
    always_comb begin
        in_win  = (addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS]);
        in_span = (addr[WIN_BITS-1:0] < REG_SPAN);
        aligned = (addr[1:0] == 2'b00);
        hit     = in_win & in_span & aligned;
        err     = in_win & ~(in_span & aligned);
    end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave to register-file bridge with req/ack handshake and wait states.
// Optional REQ timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_reg_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_W    = 32,
    parameter int unsigned           DATA_W    = 32,
    parameter int unsigned           WIN_BITS  = 12,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [WIN_BITS-1:0]   REG_SPAN  = WIN_BITS'(DEF_REG_SPAN),
    parameter int unsigned           TIMEOUT   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_W-1:0]     i_paddr,
    input  logic [DATA_W-1:0]     i_pwdata,
    input  logic [DATA_W/8-1:0]   i_pstrb,
    output logic [DATA_W-1:0]     o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic                  o_req,
    output logic                  o_we,
    output logic [WIN_BITS-1:0]   o_addr,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_wstrb,
    input  logic                  i_ack,
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic                  i_error
);

    localparam int unsigned STRB_W = DATA_W / 8;

    // reject illegal configurations at elaboration
    if ((DATA_W % 8 != 0) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_param
        $error("apb_reg_bridge: DATA_W must be a multiple of 8 and TIMEOUT in 2..255");
    end

    state_e              state;
    state_e              state_nxt;
    resp_e               resp;
    logic                req_nxt;
    logic                pready_nxt;
    logic                pslverr_nxt;
    logic [DATA_W-1:0]   prdata_nxt;
    logic                latch;
    logic                dec_hit;
    logic                dec_err;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
    logic [TMO_CNT_W-1:0] cnt;
    logic [TMO_CNT_W-1:0] cnt_nxt;
`endif

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .WIN_BITS  (WIN_BITS),
        .BASE_ADDR (BASE_ADDR),
        .REG_SPAN  (REG_SPAN)
    ) u_dec (
        .addr (i_paddr),
        .hit  (dec_hit),
        .err  (dec_err)
    );

    // next state and next values of the registered handshake outputs
    always_comb begin
        state_nxt  = state;
        req_nxt    = 1'b0;
        pready_nxt = 1'b0;
        resp       = RESP_OK;
        prdata_nxt = '0;
        latch      = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_nxt    = cnt;
`endif
        case (state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    latch = 1'b1;
                    if (dec_hit) begin
                        state_nxt = REQ;
                        req_nxt   = 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                    end else begin
                        state_nxt  = RESP;
                        pready_nxt = 1'b1;
                        resp       = dec_err ? RESP_ERR : RESP_OK;
                    end
                end
            end
            REQ: begin
                if (!i_psel) begin
                    // master abandoned the transfer: drop the request silently
                    state_nxt = IDLE;
                end else if (i_ack) begin
                    state_nxt  = RESP;
                    pready_nxt = 1'b1;
                    resp       = i_error ? RESP_ERR : RESP_OK;
                    if (!o_we && !i_error) begin
                        prdata_nxt = i_rdata;
                    end
`ifdef APB_BRIDGE_TIMEOUT_EN
                end else if (cnt == TMO_LAST) begin
                    state_nxt  = RESP;
                    pready_nxt = 1'b1;
                    resp       = RESP_ERR;
                end else begin
                    req_nxt = 1'b1;
                    cnt_nxt = cnt + TMO_CNT_W'(1);
                end
`else
                end else begin
                    req_nxt = 1'b1;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        pslverr_nxt = (resp == RESP_ERR);
    end

    // state register and registered APB / request outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_req     <= 1'b0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
        end else begin
            state     <= state_nxt;
            o_req     <= req_nxt;
            o_pready  <= pready_nxt;
            o_pslverr <= pslverr_nxt;
            o_prdata  <= prdata_nxt;
        end
    end

    // access fields captured at the setup phase and held through REQ
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
            o_wstrb <= '0;
        end else if (latch) begin
            o_we    <= i_pwrite;
            o_addr  <= i_paddr[WIN_BITS-1:0];
            o_wdata <= i_pwdata;
            o_wstrb <= i_pwrite ? i_pstrb : STRB_W'(0);
        end
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    // cycles spent waiting for i_ack in REQ
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: directed table, hand-written
// reset/abort sequences and randomized transfers against a behavioural model.
// Honours APB_BRIDGE_TIMEOUT_EN the same way as the design.
module tb_apb_reg_bridge;

    localparam logic [31:0] BASE   = 32'h4000_2000;
    localparam int          SPAN   = 32'h18;
    localparam int          TMO    = 16;
    localparam int          LIMIT  = 40;

    logic        i_clk;
    logic        i_rst;
    logic        i_psel;
    logic        i_penable;
    logic        i_pwrite;
    logic [31:0] i_paddr;
    logic [31:0] i_pwdata;
    logic [3:0]  i_pstrb;
    logic [31:0] o_prdata;
    logic        o_pready;
    logic        o_pslverr;
    logic        o_req;
    logic        o_we;
    logic [11:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_error;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        logic        x_req;
        logic        x_err;
        logic [31:0] x_rdata;
        int          x_cyc;
    } vec_t;

    vec_t tbl[$];

    apb_reg_bridge dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_psel    (i_psel),
        .i_penable (i_penable),
        .i_pwrite  (i_pwrite),
        .i_paddr   (i_paddr),
        .i_pwdata  (i_pwdata),
        .i_pstrb   (i_pstrb),
        .o_prdata  (o_prdata),
        .o_pready  (o_pready),
        .o_pslverr (o_pslverr),
        .o_req     (o_req),
        .o_we      (o_we),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .o_wstrb   (o_wstrb),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_error   (i_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".prdata"}, o_prdata, 32'h0);
        check({tag, ".pready"}, 32'(o_pready), 32'h0);
        check({tag, ".pslverr"}, 32'(o_pslverr), 32'h0);
        check({tag, ".req"}, 32'(o_req), 32'h0);
        check({tag, ".we"}, 32'(o_we), 32'h0);
        check({tag, ".addr"}, 32'(o_addr), 32'h0);
        check({tag, ".wdata"}, o_wdata, 32'h0);
        check({tag, ".wstrb"}, 32'(o_wstrb), 32'h0);
    endtask

    function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                                int dly, logic [31:0] rdata, logic err, logic x_req, logic x_err,
                                logic [31:0] x_rdata, int x_cyc);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.dly = dly;
        v.rdata = rdata; v.err = err; v.x_req = x_req; v.x_err = x_err;
        v.x_rdata = x_rdata; v.x_cyc = x_cyc;
        return v;
    endfunction

    // Reference model: the expected response follows from address arithmetic
    // and the responder's ack delay (ack in REQ cycle dly+1).
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        int   off = int'(v.addr % 4096);
        bit   in_win = (v.addr / 4096) == (BASE / 4096);
        r.x_req = 0; r.x_err = 0; r.x_rdata = 0; r.x_cyc = 1;
        if (in_win && (off >= SPAN || (v.addr % 4) != 0)) begin
            r.x_err = 1;
        end else if (in_win) begin
            r.x_req = 1;
`ifdef APB_BRIDGE_TIMEOUT_EN
            if (v.dly >= TMO) begin
                r.x_err = 1;
                r.x_cyc = TMO + 1;
                return r;
            end
`endif
            r.x_cyc = v.dly + 2;
            r.x_err = v.err;
            if (!v.wr && !v.err) r.x_rdata = v.rdata;
        end
        return r;
    endfunction

    // One APB transfer with an emulated register responder; returns in the
    // cycle after PREADY with the bus idle, so a following call is back-to-back.
    task automatic xfer(input vec_t v, input string tag);
        int   k = 1;
        int   reqc = 0;
        bit   done = 0;
        bit   saw = 0;
        logic ack;
        i_psel = 1; i_penable = 0; i_pwrite = v.wr; i_paddr = v.addr;
        i_pwdata = v.wdata; i_pstrb = v.strb; i_ack = 0;
        tick();
        i_penable = 1;
        while (!done && k <= LIMIT) begin
            if (o_pready) begin
                done = 1;
                i_ack = 0;
                check({tag, ".cycles"}, 32'(k), 32'(v.x_cyc));
                check({tag, ".pslverr"}, 32'(o_pslverr), 32'(v.x_err));
                check({tag, ".prdata"}, o_prdata, v.x_rdata);
                check({tag, ".req_at_ready"}, 32'(o_req), 32'h0);
                check({tag, ".req_seen"}, 32'(saw), 32'(v.x_req));
            end else begin
                check({tag, ".prdata_idle"}, o_prdata, 32'h0);
                if (o_req) begin
                    reqc++;
                    if (!saw) begin
                        check({tag, ".addr"}, 32'(o_addr), v.addr % 4096);
                        check({tag, ".we"}, 32'(o_we), 32'(v.wr));
                        check({tag, ".wstrb"}, 32'(o_wstrb), v.wr ? 32'(v.strb) : 32'h0);
                        if (v.wr) check({tag, ".wdata"}, o_wdata, v.wdata);
                    end
                    saw = 1;
                    ack = (reqc == v.dly + 1);
                    i_ack   = ack;
                    i_rdata = ack ? v.rdata : $urandom;
                    i_error = ack ? v.err : 1'($urandom_range(0, 1));
                end else begin
                    i_ack = 0;
                end
                tick();
                k++;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL %s.timeout: got no PREADY within %0d cycles expected %0d", tag, LIMIT, v.x_cyc);
        end
        tick();
        i_psel = 0; i_penable = 0; i_ack = 0;
    endtask

    initial begin
        vec_t v;
        i_rst = 1; i_psel = 0; i_penable = 0; i_pwrite = 0; i_paddr = 0;
        i_pwdata = 0; i_pstrb = 0; i_ack = 0; i_rdata = 0; i_error = 0;
        repeat (3) tick();
        check_all_zero("reset");
        i_rst = 0;
        tick();

        // directed vectors
        tbl.push_back(mk(1, 32'h4000_2004, 32'hA5A5_1234, 4'hF, 0, 32'h0, 0, 1, 0, 32'h0, 2));
        tbl.push_back(mk(0, 32'h4000_2010, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 5));
        tbl.push_back(mk(0, 32'h4000_2020, 32'h0, 4'h0, 0, 32'h1111_1111, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 32'h4000_2006, 32'h0, 4'h0, 0, 32'h2222_2222, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 32'h4000_3000, 32'h0, 4'h0, 0, 32'h3333_3333, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 32'h4000_2000, 32'h0F0F_0F0F, 4'h5, 0, 32'h0, 1, 1, 1, 32'h0, 2));
        tbl.push_back(mk(0, 32'h4000_2014, 32'h0, 4'h0, 1, 32'h1234_5678, 1, 1, 1, 32'h0, 3));
        tbl.push_back(mk(1, 32'h4000_2014, 32'h7777_8888, 4'h3, 2, 32'h0, 0, 1, 0, 32'h0, 4));
        tbl.push_back(mk(0, 32'h4000_2018, 32'h0, 4'h0, 0, 32'h4444_4444, 0, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 32'h4000_1FFC, 32'h0, 4'h0, 0, 32'h5555_5555, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 32'h4000_2FFC, 32'h0, 4'h0, 0, 32'h6666_6666, 0, 0, 1, 32'h0, 1));
`ifdef APB_BRIDGE_TIMEOUT_EN
        tbl.push_back(mk(0, 32'h4000_2008, 32'h0, 4'h0, 100, 32'h9999_9999, 0, 1, 1, 32'h0, 17));
        tbl.push_back(mk(0, 32'h4000_200C, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D, 17));
`else
        tbl.push_back(mk(0, 32'h4000_2008, 32'h0, 4'h0, 20, 32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D, 22));
`endif
        foreach (tbl[i]) xfer(tbl[i], $sformatf("vec%0d", i));

        // reset in the second REQ cycle drops the transfer
        i_psel = 1; i_penable = 0; i_pwrite = 1; i_paddr = 32'h4000_2008;
        i_pwdata = 32'h1122_3344; i_pstrb = 4'hF;
        tick();
        i_penable = 1;
        check("rstmid.req1", 32'(o_req), 32'h1);
        tick();
        check("rstmid.req2", 32'(o_req), 32'h1);
        i_rst = 1;
        tick();
        check_all_zero("rstmid");
        i_rst = 0; i_psel = 0; i_penable = 0;
        tick();
        xfer(mk(0, 32'h4000_2000, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 0, 1, 0, 32'h0BAD_F00D, 2), "after_rst");

        // psel drops in REQ; a late ack must not produce a response
        i_psel = 1; i_penable = 0; i_pwrite = 0; i_paddr = 32'h4000_200C;
        tick();
        i_penable = 1;
        check("abort.req1", 32'(o_req), 32'h1);
        tick();
        i_psel = 0; i_penable = 0;
        tick();
        check("abort.req_drop", 32'(o_req), 32'h0);
        check("abort.no_ready", 32'(o_pready), 32'h0);
        i_ack = 1; i_rdata = 32'hBAAD_BAAD; i_error = 1;
        tick();
        i_ack = 0;
        check("stray.no_ready", 32'(o_pready), 32'h0);
        check("stray.no_req", 32'(o_req), 32'h0);
        tick();
        check("stray.no_ready2", 32'(o_pready), 32'h0);
        xfer(mk(0, 32'h4000_200C, 32'h0, 4'h0, 1, 32'h5A5A_A5A5, 0, 1, 0, 32'h5A5A_A5A5, 3), "after_abort");

        // randomized transfers against the model
        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 9);
            v.wr = 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.strb = 4'($urandom_range(0, 15));
            v.rdata = $urandom;
            v.err = ($urandom_range(0, 4) == 0);
            v.dly = $urandom_range(0, 5);
`ifdef APB_BRIDGE_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) v.dly = $urandom_range(14, 18);
`endif
            if (sel < 6)      v.addr = BASE + 32'(4 * $urandom_range(0, 5));
            else if (sel < 7) v.addr = BASE + 32'($urandom_range(SPAN, 4095));
            else if (sel < 8) v.addr = BASE + 32'(4 * $urandom_range(0, 5) + $urandom_range(1, 3));
            else              v.addr = $urandom & 32'hFFFF_EFFF ^ 32'h0000_1000 ^ BASE;
            v = model(v);
            xfer(v, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
